upe_twos_to_signmag64: RTL
==========================

Name: upe_twos_to_signmag64

Overview:
- Multi-cycle converter from two's complement to sign-magnitude. It is the reverse direction of the negate path: it recovers sign and |x| from a signed word.
- Magnitude is built slice by slice, LSB slice first. Each slice is conditionally inverted and then incremented, with the carry registered between cycles. This keeps the adder at SLICE bits instead of a full-width carry chain.
- Sits between signed accumulator outputs and the sign-magnitude uncertainty datapath. Valid/ready on both sides.

Parameters:
- WIDTH, 64, data word width; must be an integer multiple of SLICE.
- SLICE, 16, bits processed per cycle.
- NSLICE, WIDTH/SLICE (4), derived localparam; not user-set.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  in_data holds a valid word.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  two's complement operand.
- out_valid  output  1  out_sign/out_mag/out_minneg are valid.
- out_ready  input  1  consumer takes the result this cycle.
- out_sign  output  1  1 = operand was negative.
- out_mag  output  WIDTH  unsigned magnitude |in_data|.
- out_minneg  output  1  operand was the most-negative value (1 followed by zeros); magnitude 2^(WIDTH-1) does not fit a signed WIDTH-bit word.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid, out_sign, out_mag, out_minneg, busy, slice counter and carry all cleared to 0.
  - in_ready=1, but no transfer is taken while rst_n is low.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the work register; sign_r=in_data[WIDTH-1]; carry_r=sign_r; cnt=0; go to RUN.
- State RUN (busy=1, in_ready=0, out_valid=0):
  - Each cycle, with s = work[cnt*SLICE +: SLICE]: s' = (sign_r ? ~s : s) + carry_r, computed SLICE bits wide.
  - Write s' back into the slice. carry_r = carry-out of that add.
  - cnt++. When cnt==NSLICE-1 is processed, go to DONE.
  - For a positive operand, carry stays 0 and slices pass through unchanged.
- State DONE:
  - out_valid=1; out_mag=work; out_sign=sign_r.
  - out_minneg = sign_r && work[WIDTH-1].
- Latency: acceptance at edge N puts out_valid high after edge N+NSLICE, i.e. 4 RUN cycles and then DONE.
- Output handshake:
  - Outputs stay stable while out_valid && !out_ready, for any number of cycles.
  - in_ready=0 in DONE unless out_ready=1.
  - DONE with out_ready=1 and in_valid=0: go to IDLE. out_valid deasserts; out_mag/out_sign/out_minneg hold their last values.
  - DONE with out_ready=1 and in_valid=1: the result is consumed and the new word is accepted on the same edge, going straight to RUN. Minimum spacing is NSLICE+1 cycles per word.
- Zero input: sign 0, mag 0, minneg 0.
- Most-negative input: sign 1, mag 0x8000_0000_0000_0000, minneg 1. No saturation; the magnitude is exact as an unsigned value.
- Carry is never dropped between slices. The carry-out of the final slice is 1 only for a zero operand with sign set, which cannot occur, so it is discarded.
- Reset asserted mid-RUN or mid-DONE:
  - Aborts immediately with all outputs cleared.
  - The partial result is never presented.
  - The first transaction after release must be correct.
- in_data may change freely after acceptance; only the latched copy is used.

Test Plan:
- in=0x0000_0000_0000_0005, out_ready=1 -> out_valid 4 cycles after accept; sign=0, mag=0x0000_0000_0000_0005, minneg=0.
- in=0xFFFF_FFFF_FFFF_FFFB (-5) -> sign=1, mag=0x0000_0000_0000_0005, minneg=0.
- in=0xFFFF_0000_0000_0000 -> sign=1, mag=0x0001_0000_0000_0000. Checks carry rippling through slices 0-2 across cycles.
- in=0x8000_0000_0000_0000 -> sign=1, mag=0x8000_0000_0000_0000, minneg=1. Also in=0 -> sign=0, mag=0.
- Hold out_ready=0 for 10 cycles after out_valid:
  - outputs constant and in_ready=0 throughout;
  - then raise out_ready with in_valid=1, in=0xFFFF_FFFF_FFFF_FFFF;
  - same-edge accept; next result sign=1, mag=1.
- Random 10k operands, random in_valid/out_ready gaps -> every result matches the reference abs/sign model, in order, none lost or duplicated.
- Reset pulse of any length (including one shorter than a clock period) two cycles into RUN:
  - all outputs 0 and no out_valid;
  - after release, in=0xFFFF_FFFF_FFFF_FF00 -> sign=1, mag=0x100.

Source files
------------

// File: rtl/upe_twos_to_signmag64.sv
// upe_twos_to_signmag64: multi-cycle two's complement to sign-magnitude converter.
// The magnitude is formed one SLICE-bit chunk per cycle, LSB slice first: each slice
// is conditionally inverted and incremented by the carry registered from the previous
// slice, so only a SLICE-bit adder is needed. Valid/ready handshakes on both sides.
module upe_twos_to_signmag64 #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_minneg,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic             sign_r;
    logic             carry_r;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] cur_slice;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] work_nxt;
    logic             accept;

    // Input is taken in IDLE, or in DONE when the current result leaves on the same edge.
    always_comb begin
        in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Select the slice addressed by cnt from the work register.
    always_comb begin
        cur_slice = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (cnt == CW'(i)) begin
                cur_slice = work[i*SLICE +: SLICE];
            end
        end
    end

    // Conditional invert plus incoming carry; the extra MSB is the carry to the next slice.
    always_comb begin
        sum = {1'b0, (sign_r ? ~cur_slice : cur_slice)} + {{SLICE{1'b0}}, carry_r};
    end

    // Work register with the current slice replaced by its converted value.
    always_comb begin
        work_nxt = work;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (cnt == CW'(i)) begin
                work_nxt[i*SLICE +: SLICE] = sum[SLICE-1:0];
            end
        end
    end

    // Control FSM with registered outputs; reset aborts any conversion in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            work       <= '0;
            sign_r     <= 1'b0;
            carry_r    <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_sign   <= 1'b0;
            out_mag    <= '0;
            out_minneg <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if ((state == ST_DONE) && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    // A new word enters here; in DONE this coincides with the result leaving.
                    if (accept) begin
                        work    <= in_data;
                        sign_r  <= in_data[WIDTH-1];
                        carry_r <= in_data[WIDTH-1];
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    work    <= work_nxt;
                    carry_r <= sum[SLICE];
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Outputs load from work_nxt so the final slice is included.
                        cnt        <= '0;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        out_mag    <= work_nxt;
                        out_sign   <= sign_r;
                        out_minneg <= sign_r & work_nxt[WIDTH-1];
                        state      <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
